// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared constants and helpers for the inter-board game link
//
// Purpose: sync byte, command codes, default bit timing, frame state encoding
//          and the checksum rule, shared by the link transmitter and receiver.
// Ports:   none (package).
package uart_link_pkg;

  localparam logic [7:0] LINK_SYNC_BYTE = 8'hA5;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_STOP  = 8'h02;
  localparam logic [7:0] CMD_SCORE = 8'h03;

  // 40 MHz / 115200 baud, truncated
  localparam int CLKS_PER_BIT_DEFAULT = 347;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } tx_state_e;

  // Checksum byte closing every frame
  function automatic logic [7:0] frame_chk(input logic [7:0] sync_b,
                                           input logic [7:0] cmd_b,
                                           input logic [7:0] data_b);
    return sync_b ^ cmd_b ^ data_b;
  endfunction

endpackage

// File: rtl/uart_game_tx_if.sv
// rtl/uart_game_tx_if.sv - game message handshake between game FSM and link transmitter
//
// Purpose: groups the message valid/ready handshake and its payload.
// Signals: msg_valid (request, held until accepted), msg_cmd[7:0], msg_data[7:0],
//          msg_ready (transmitter can accept this cycle).
// Modports: master = message source (game FSM), slave = transmitter.
interface uart_game_tx_if;
  logic       msg_valid;
  logic [7:0] msg_cmd;
  logic [7:0] msg_data;
  logic       msg_ready;

  modport master (output msg_valid, output msg_cmd, output msg_data, input msg_ready);
  modport slave  (input msg_valid, input msg_cmd, input msg_data, output msg_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-time counter for the UART link
//
// Purpose: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Ports:   pclk, rst_n (async active-low), clear_i (force count to 0),
//          tick_o (high while the count is CLKS_PER_BIT-1).
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_game_tx.sv
// rtl/uart_game_tx.sv - game link transmitter: one message -> 4-byte 8N1 frame
//
// Purpose: accepts (cmd, data) on a valid/ready handshake and sends
//          SYNC, cmd, data, checksum as 8N1 bytes, followed by GAP_BITS idle bits.
// Ports:   pclk, rst_n (async active-low), msg (slave handshake: msg_valid,
//          msg_cmd, msg_data in; msg_ready out), tx (serial out, idle high),
//          busy (frame or gap in progress, = !msg_ready).
module uart_game_tx
  import uart_link_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0] SYNC_BYTE    = LINK_SYNC_BYTE,
  parameter int         GAP_BITS     = 1
) (
  input  logic           pclk,
  input  logic           rst_n,
  uart_game_tx_if.slave  msg,
  output logic           tx,
  output logic           busy
);

  localparam logic [3:0] GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  tx_state_e  state_q, state_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [3:0] gap_idx_q, gap_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] cmd_q, cmd_d, data_q, data_d, chk_q, chk_d;
  logic       tx_q, tx_d;
  logic       tick, baud_clear;

  assign msg.msg_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign tx            = tx_q;

  // Counter is held at 0 while idle so the first bit after acceptance is full length
  assign baud_clear = (state_q == ST_IDLE) || (state_d != state_q);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .clear_i (baud_clear),
    .tick_o  (tick)
  );

  // tx_d is the line level for the state being entered, so tx changes on the
  // same edge as the state and stays aligned with the baud counter.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    gap_idx_d  = gap_idx_q;
    shift_d    = shift_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    chk_d      = chk_q;
    tx_d       = tx_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (msg.msg_valid) begin
          cmd_d      = msg.msg_cmd;
          data_d     = msg.msg_data;
          chk_d      = frame_chk(SYNC_BYTE, msg.msg_cmd, msg.msg_data);
          byte_idx_d = 2'd0;
          shift_d    = SYNC_BYTE;
          tx_d       = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = ST_START;
            tx_d       = 1'b0;
            case (byte_idx_q)
              2'd0:    shift_d = cmd_q;
              2'd1:    shift_d = data_q;
              default: shift_d = chk_q;
            endcase
          end else if (GAP_BITS > 0) begin
            state_d   = ST_GAP;
            gap_idx_d = 4'd0;
            tx_d      = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      ST_GAP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (gap_idx_q == GAP_LAST) state_d = ST_IDLE;
          else                       gap_idx_d = gap_idx_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      gap_idx_q  <= '0;
      shift_q    <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      chk_q      <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      gap_idx_q  <= gap_idx_d;
      shift_q    <= shift_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      chk_q      <= chk_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_game_tx.sv
// tb/tb_uart_game_tx.sv - self-checking bench for uart_game_tx
module tb_uart_game_tx;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic [2:0] vld;
  logic [7:0] cmd_r [3];
  logic [7:0] dat_r [3];
  logic       tx_a, tx_b, tx_c, busy_a, busy_b, busy_c;
  int         errors = 0;
  int         checks = 0;

  always #5 pclk = ~pclk;

  uart_game_tx_if ifa ();
  uart_game_tx_if ifb ();
  uart_game_tx_if ifc ();

  assign ifa.msg_valid = vld[0];
  assign ifa.msg_cmd   = cmd_r[0];
  assign ifa.msg_data  = dat_r[0];
  assign ifb.msg_valid = vld[1];
  assign ifb.msg_cmd   = cmd_r[1];
  assign ifb.msg_data  = dat_r[1];
  assign ifc.msg_valid = vld[2];
  assign ifc.msg_cmd   = cmd_r[2];
  assign ifc.msg_data  = dat_r[2];

  uart_game_tx #(.CLKS_PER_BIT(4), .GAP_BITS(1)) dut_a (
    .pclk(pclk), .rst_n(rst_n), .msg(ifa), .tx(tx_a), .busy(busy_a));
  uart_game_tx #(.CLKS_PER_BIT(347), .GAP_BITS(1)) dut_b (
    .pclk(pclk), .rst_n(rst_n), .msg(ifb), .tx(tx_b), .busy(busy_b));
  uart_game_tx #(.CLKS_PER_BIT(4), .GAP_BITS(0)) dut_c (
    .pclk(pclk), .rst_n(rst_n), .msg(ifc), .tx(tx_c), .busy(busy_c));

  function automatic logic tx_of(input int d);
    case (d)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return ifa.msg_ready;
      1:       return ifb.msg_ready;
      default: return ifc.msg_ready;
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends (or continues with an already pending) message on DUT d and checks the
  // line against the frame built from the bytes. Sample n is taken at the falling
  // edge n cycles after the acceptance edge. With hold=1, msg_valid stays high,
  // the inputs are scrambled mid-frame and then set to (nc, nd) for the next frame.
  task automatic run_frame(input string nm, input int d, input int cpb, input int gap,
                           input logic [7:0] c, input logic [7:0] dt,
                           input bit pending, input bit hold,
                           input logic [7:0] nc, input logic [7:0] nd);
    logic       smp[$];
    logic       rdys[$];
    logic [7:0] eb[4];
    logic [7:0] v;
    logic       e;
    int         L, guard, first_rdy, bad, bad_w, k, pos;
    L = (40 + gap) * cpb;
    eb[0] = 8'hA5; eb[1] = c; eb[2] = dt; eb[3] = 8'hA5 ^ c ^ dt;
    if (!pending) begin
      @(negedge pclk);
      vld[d] = 1'b1; cmd_r[d] = c; dat_r[d] = dt;
    end
    guard = 0;
    while (!rdy_of(d) && guard < 20000) begin
      @(negedge pclk);
      guard++;
    end
    check({nm, "_ready_before"}, 32'(rdy_of(d)), 32'd1);
    for (int n = 0; n <= L; n++) begin
      @(negedge pclk);
      if (n == 0) begin
        if (!hold) vld[d] = 1'b0;
        else begin cmd_r[d] = ~c; dat_r[d] = 8'($urandom); end
        check({nm, "_busy"}, 32'(busy_of(d)), 32'd1);
        check({nm, "_ready_drop"}, 32'(rdy_of(d)), 32'd0);
      end
      if (hold && n == 30 * cpb) begin cmd_r[d] = nc; dat_r[d] = nd; end
      smp.push_back(tx_of(d));
      rdys.push_back(rdy_of(d));
    end
    check({nm, "_start_latency"}, 32'(smp[0]), 32'd0);
    first_rdy = -1;
    for (int n = L; n >= 0; n--) if (rdys[n] === 1'b1) first_rdy = n;
    check({nm, "_ready_return"}, 32'(first_rdy), 32'(L));
    bad = 0;
    for (int n = 0; n <= L; n++) begin
      if (n < 40 * cpb) begin
        k = n / cpb; pos = k % 10;
        if (pos == 0) e = 1'b0;
        else if (pos == 9) e = 1'b1;
        else e = eb[k / 10][pos - 1];
      end else e = 1'b1;
      if (smp[n] !== e) bad++;
    end
    check({nm, "_bitstream"}, 32'(bad), 32'd0);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) v[i] = smp[(b * 10 + 1 + i) * cpb + cpb / 2];
      check($sformatf("%s_byte%0d", nm, b), 32'(v), 32'(eb[b]));
    end
    bad_w = 0;
    for (int n = 1; n <= L; n++) if (smp[n] !== smp[n - 1] && (n % cpb) != 0) bad_w++;
    check({nm, "_bit_width"}, 32'(bad_w), 32'd0);
  endtask

  initial begin
    logic [7:0] rc, rd, nc, nd;
    int bad;
    rst_n = 1'b0;
    vld = '0;
    for (int i = 0; i < 3; i++) begin cmd_r[i] = '0; dat_r[i] = '0; end

    repeat (5) @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_tx%0d", d), 32'(tx_of(d)), 32'd1);
      check($sformatf("rst_ready%0d", d), 32'(rdy_of(d)), 32'd1);
      check($sformatf("rst_busy%0d", d), 32'(busy_of(d)), 32'd0);
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge pclk);
      for (int d = 0; d < 3; d++)
        if (tx_of(d) !== 1'b1 || rdy_of(d) !== 1'b1 || busy_of(d) !== 1'b0) bad++;
    end
    check("idle_after_reset", 32'(bad), 32'd0);

    run_frame("a_start", 0, 4, 1, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00);
    run_frame("b_score", 1, 347, 1, 8'h03, 8'h5C, 0, 0, 8'h00, 8'h00);

    run_frame("a_hold1", 0, 4, 1, 8'h02, 8'h11, 0, 1, 8'h03, 8'h22);
    run_frame("a_hold2", 0, 4, 1, 8'h03, 8'h22, 1, 0, 8'h00, 8'h00);

    for (int r = 0; r < 3; r++) begin
      rc = 8'($urandom); rd = 8'($urandom);
      run_frame($sformatf("a_rand%0d", r), 0, 4, 1, rc, rd, 0, 0, 8'h00, 8'h00);
    end

    // Reset in the middle of the (all-zero) data byte
    @(negedge pclk);
    vld[0] = 1'b1; cmd_r[0] = 8'($urandom); dat_r[0] = 8'h00;
    @(negedge pclk);
    vld[0] = 1'b0;
    repeat (102) @(negedge pclk);
    check("mid_data_tx_low", 32'(tx_a), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_async", 32'(tx_a), 32'd1);
    check("rst_ready_async", 32'(ifa.msg_ready), 32'd1);
    @(negedge pclk);
    rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge pclk);
      if (tx_a !== 1'b1 || ifa.msg_ready !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    check("no_resume_after_rst", 32'(bad), 32'd0);
    rc = 8'($urandom); rd = 8'($urandom);
    run_frame("a_after_rst", 0, 4, 1, rc, rd, 0, 0, 8'h00, 8'h00);

    rc = 8'($urandom); rd = 8'($urandom); nc = 8'($urandom); nd = 8'($urandom);
    run_frame("c_gap0_1", 2, 4, 0, rc, rd, 0, 1, nc, nd);
    run_frame("c_gap0_2", 2, 4, 0, nc, nd, 1, 0, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
